// File: rtl/z80_int_ctrl.sv
// Z80 maskable-interrupt controller: queues timer strobes in a saturating pending
// counter, drives /INT per request, retires on acknowledge or hold-window timeout.
module z80_int_ctrl #(
    parameter int HOLD_CYCLES = 32,
    parameter int PEND_MAX    = 3
) (
    input  logic       clk_z80,
    input  logic       rst_n,
    input  logic       int_stb,
    input  logic       int_en,
    input  logic       m1_n,
    input  logic       iorq_n,
    input  logic       lost_clr,
    output logic       int_n,
    output logic       ack_stb,
    output logic [2:0] pend,
    output logic [7:0] lost_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        ACKWAIT = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [2:0] PEND_TOP  = 3'(PEND_MAX);

    state_t     state_reg;
    logic [7:0] hold_cnt_reg;

    logic       ack_evt;
    logic       tmo_evt;
    logic       dec_evt;
    logic       drop_evt;
    logic [2:0] pend_next;
    logic [8:0] lost_sum;
    logic [7:0] lost_next;

    // Retirement events; acknowledge outranks enable-drop, which outranks timeout.
    always_comb begin
        ack_evt   = (state_reg == ASSERT) && !m1_n && !iorq_n;
        tmo_evt   = (state_reg == ASSERT) && !ack_evt && int_en && (hold_cnt_reg == HOLD_LAST);
        dec_evt   = ack_evt || tmo_evt;
        drop_evt  = int_stb && !dec_evt && (pend == PEND_TOP);

        pend_next = pend;
        if (int_stb && !dec_evt && (pend != PEND_TOP)) begin
            pend_next = pend + 3'd1;
        end else if (dec_evt && !int_stb) begin
            pend_next = pend - 3'd1;
        end

        lost_sum  = {1'b0, lost_cnt} + 9'(tmo_evt) + 9'(drop_evt);
        lost_next = lost_sum[8] ? 8'hff : lost_sum[7:0];
        if (lost_clr) begin
            lost_next = 8'd0;
        end
    end

    always_ff @(posedge clk_z80) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= 8'd0;
            int_n        <= 1'b1;
            ack_stb      <= 1'b0;
            pend         <= 3'd0;
            lost_cnt     <= 8'd0;
        end else begin
            ack_stb  <= 1'b0;
            pend     <= pend_next;
            lost_cnt <= lost_next;
            case (state_reg)
                IDLE: begin
                    int_n <= 1'b1;
                    if ((pend != 3'd0) && int_en) begin
                        state_reg    <= ASSERT;
                        int_n        <= 1'b0;
                        hold_cnt_reg <= 8'd0;
                    end
                end
                ASSERT: begin
                    if (ack_evt) begin
                        state_reg <= ACKWAIT;
                        int_n     <= 1'b1;
                        ack_stb   <= 1'b1;
                    end else if (!int_en) begin
                        state_reg <= IDLE;
                        int_n     <= 1'b1;
                    end else if (tmo_evt) begin
                        state_reg <= GAP;
                        int_n     <= 1'b1;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 8'd1;
                    end
                end
                // Hold off until the acknowledge cycle ends so it retires only once.
                ACKWAIT: begin
                    int_n <= 1'b1;
                    if (m1_n && iorq_n) begin
                        state_reg <= GAP;
                    end
                end
                GAP: begin
                    int_n     <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    int_n     <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z80_int_ctrl.sv
// Randomised and directed bench for z80_int_ctrl against a cycle-level behavioural model.
module tb_z80_int_ctrl;

    localparam int HOLD = 32;
    localparam int PMAX = 3;

    logic       clk_z80 = 1'b0;
    logic       rst_n = 1'b0;
    logic       int_stb = 1'b0;
    logic       int_en = 1'b0;
    logic       m1_n = 1'b1;
    logic       iorq_n = 1'b1;
    logic       lost_clr = 1'b0;
    logic       int_n;
    logic       ack_stb;
    logic [2:0] pend;
    logic [7:0] lost_cnt;

    z80_int_ctrl #(.HOLD_CYCLES(HOLD), .PEND_MAX(PMAX)) dut (
        .clk_z80(clk_z80), .rst_n(rst_n), .int_stb(int_stb), .int_en(int_en),
        .m1_n(m1_n), .iorq_n(iorq_n), .lost_clr(lost_clr),
        .int_n(int_n), .ack_stb(ack_stb), .pend(pend), .lost_cnt(lost_cnt)
    );

    always #5 clk_z80 = ~clk_z80;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    // Model: line level, age of the current assertion, forced-high cycles left, and
    // whether we are still waiting for the acknowledge cycle to end.
    bit m_int_n = 1'b1;
    bit m_ack = 1'b0;
    int m_pend = 0;
    int m_lost = 0;
    int m_age = 0;
    int m_cool = 0;
    bit m_wrel = 1'b0;

    task automatic model_step();
        bit dec, tmo, ack, drop;
        int p;
        dec = 0; tmo = 0; ack = 0; drop = 0;
        if (!rst_n) begin
            m_int_n = 1; m_ack = 0; m_pend = 0; m_lost = 0;
            m_age = 0; m_cool = 0; m_wrel = 0;
        end else begin
            if (!m_int_n) begin
                if (!m1_n && !iorq_n) begin
                    ack = 1; dec = 1; m_int_n = 1; m_wrel = 1;
                end else if (!int_en) begin
                    m_int_n = 1;
                end else if (m_age + 1 == HOLD) begin
                    tmo = 1; dec = 1; m_int_n = 1; m_cool = 1;
                end else begin
                    m_age = m_age + 1;
                end
            end else if (m_wrel) begin
                if (m1_n && iorq_n) begin
                    m_wrel = 0; m_cool = 1;
                end
            end else if (m_cool > 0) begin
                m_cool = m_cool - 1;
            end else if (m_pend != 0 && int_en) begin
                m_int_n = 0; m_age = 0;
            end
            if (!(dec && int_stb)) begin
                p = m_pend - int'(dec) + int'(int_stb);
                if (p > PMAX) begin
                    p = PMAX; drop = 1;
                end
                m_pend = p;
            end
            m_ack = ack;
            if (lost_clr) m_lost = 0;
            else m_lost = (m_lost + int'(tmo) + int'(drop) > 255) ? 255 : m_lost + int'(tmo) + int'(drop);
        end
    endtask

    task automatic tick();
        @(posedge clk_z80);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model on the falling edge.
    always @(negedge clk_z80) begin
        if (cmp_en) begin
            checks++;
            if (int_n !== m_int_n || ack_stb !== m_ack || pend !== 3'(m_pend) || lost_cnt !== 8'(m_lost)) begin
                failures++;
                $display("FAIL model: got int_n=%b ack=%b pend=%0d lost=%0d expected int_n=%b ack=%b pend=%0d lost=%0d at %0t",
                         int_n, ack_stb, pend, lost_cnt, m_int_n, m_ack, m_pend, m_lost, $time);
            end
        end
    end

    task automatic wait_low(input string name, output int highs);
        highs = 0;
        for (int i = 0; i < 200; i++) begin
            if (int_n == 1'b0) return;
            tick();
            if (int_n == 1'b1) highs++;
        end
        check({name, "_timeout"}, int'(int_n), 0);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, acks, highs, reassert, lost0;
        tick(); tick();
        cmp_en = 1'b1;
        check("rst_int_n", int'(int_n), 1);
        check("rst_ack", int'(ack_stb), 0);
        check("rst_pend", int'(pend), 0);
        check("rst_lost", int'(lost_cnt), 0);
        rst_n = 1'b1;

        // Single request, no acknowledge: full hold window then timeout.
        int_en = 1; int_stb = 1; tick(); int_stb = 0;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (int_n == 1'b0) n++;
        end
        check("tmo_low_cycles", n, HOLD);
        check("tmo_pend", int'(pend), 0);
        check("tmo_lost", int'(lost_cnt), 1);

        // Single request acknowledged 5 cycles after the fall, held 3 cycles.
        lost_clr = 1; tick(); lost_clr = 0;
        int_stb = 1; tick(); int_stb = 0;
        wait_low("ack_fall", highs);
        for (int i = 0; i < 5; i++) tick();
        m1_n = 0; iorq_n = 0; tick();
        check("ack_first_int_n", int'(int_n), 1);
        check("ack_first_stb", int'(ack_stb), 1);
        acks = 1; reassert = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (ack_stb) acks++;
            if (!int_n) reassert++;
        end
        m1_n = 1; iorq_n = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack_stb) acks++;
            if (!int_n) reassert++;
        end
        check("ack_pulses", acks, 1);
        check("ack_reassert", reassert, 0);
        check("ack_pend", int'(pend), 0);
        check("ack_lost", int'(lost_cnt), 0);

        // Five strobes while disabled: three queue, two lost; then drain by acknowledge.
        int_en = 0;
        for (int i = 0; i < 5; i++) begin
            int_stb = 1; tick(); int_stb = 0; tick();
        end
        check("fill_pend", int'(pend), 3);
        check("fill_lost", int'(lost_cnt), 2);
        int_en = 1; n = 0;
        for (int k = 0; k < 3; k++) begin
            int prev_high;
            prev_high = highs;
            wait_low("drain_fall", highs);
            if (k > 0) check("drain_gap_ge2", int'((prev_high + highs) >= 2), 1);
            m1_n = 0; iorq_n = 0; tick();
            if (ack_stb) n++;
            m1_n = 1; iorq_n = 1;
            highs = 1;
        end
        tick(); tick();
        check("drain_pulses", n, 3);
        check("drain_pend", int'(pend), 0);

        // Full queue with a strobe coincident with the acknowledge.
        lost_clr = 1; tick(); lost_clr = 0;
        int_en = 0; int_stb = 1;
        for (int i = 0; i < 3; i++) tick();
        int_stb = 0;
        check("coinc_pre_pend", int'(pend), 3);
        int_en = 1;
        wait_low("coinc_fall", highs);
        m1_n = 0; iorq_n = 0; int_stb = 1; tick();
        m1_n = 1; iorq_n = 1; int_stb = 0;
        check("coinc_pend", int'(pend), 3);
        check("coinc_lost", int'(lost_cnt), 0);
        check("coinc_ack", int'(ack_stb), 1);

        // Enable dropped mid-assert, then a fresh full window.
        wait_low("drop_fall", highs);
        for (int i = 0; i < 5; i++) tick();
        int_en = 0; tick();
        check("drop_int_n", int'(int_n), 1);
        check("drop_pend", int'(pend), 3);
        int_en = 1;
        wait_low("reen_fall", highs);
        n = 1;
        for (int i = 0; i < 100 && int_n == 1'b0; i++) begin
            tick();
            if (int_n == 1'b0) n++;
        end
        check("reen_low_cycles", n, HOLD);
        check("reen_pend", int'(pend), 2);
        check("reen_lost", int'(lost_cnt), 1);

        // Loss saturation, clear priority, reset mid-assert.
        rst_n = 0; tick(); rst_n = 1;
        int_en = 0; int_stb = 1;
        for (int i = 0; i < 300; i++) tick();
        check("sat_pend", int'(pend), 3);
        check("sat_lost", int'(lost_cnt), 255);
        lost_clr = 1; tick(); lost_clr = 0; int_stb = 0;
        check("clr_prio", int'(lost_cnt), 0);
        int_en = 1;
        wait_low("rst_fall", highs);
        tick(); tick(); tick();
        rst_n = 0; tick();
        check("rstmid_int_n", int'(int_n), 1);
        check("rstmid_ack", int'(ack_stb), 0);
        check("rstmid_pend", int'(pend), 0);
        check("rstmid_lost", int'(lost_cnt), 0);
        rst_n = 1;

        // Randomised traffic in blocks with varying acknowledge behaviour.
        for (int b = 0; b < 20; b++) begin
            int ack_rate, stb_rate;
            ack_rate = $urandom_range(2, 60);
            stb_rate = $urandom_range(3, 40);
            for (int i = 0; i < 1000; i++) begin
                int_stb  = ($urandom % stb_rate) == 0;
                int_en   = ($urandom % 25) != 0;
                m1_n     = ($urandom % ack_rate) != 0;
                iorq_n   = m1_n ? (($urandom % 3) != 0) : (($urandom % 4) == 0);
                lost_clr = ($urandom % 300) == 0;
                rst_n    = ($urandom % 2000) != 0;
                tick();
            end
        end
        rst_n = 1; m1_n = 1; iorq_n = 1; int_stb = 0; lost_clr = 0;
        tick(); tick();
        cmp_en = 1'b0;
        lost0 = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + lost0);
        $finish;
    end

endmodule

// File: doc/z80_int_ctrl.md
# z80_int_ctrl

Z80 maskable-interrupt controller, clocked on the Z80 clock. It takes the one-cycle `int_stb` strobes produced by the interrupt-rate timer and queues them in a saturating pending counter. It drives the Z80 `/INT` line for each queued request and retires the request on the Z80 interrupt-acknowledge cycle (M1 together with IORQ). Requests that are never acknowledged time out after a bounded hold window, and requests arriving with the queue full are counted as lost.

## Interface

Parameters:
- `HOLD_CYCLES`, default 32: maximum number of `clk_z80` cycles `int_n` stays low without an acknowledge. Legal range 2..255.
- `PEND_MAX`, default 3: pending-counter capacity. Legal range 1..7; the counter is 3 bits wide.

Ports:
- `clk_z80`  in  1  Z80 clock; the only clock.
- `rst_n`  in  1  Reset. Synchronous, active-low.
- `int_stb`  in  1  Interrupt request strobe from the timer, one cycle wide, already in the `clk_z80` domain.
- `int_en`  in  1  Interrupt enable from the port register.
- `m1_n`  in  1  Z80 /M1, synchronous to `clk_z80`.
- `iorq_n`  in  1  Z80 /IORQ, synchronous to `clk_z80`.
- `lost_clr`  in  1  Clear strobe for `lost_cnt`.
- `int_n`  out  1  Z80 /INT. Registered, active-low.
- `ack_stb`  out  1  One-cycle pulse per acknowledged interrupt.
- `pend`  out  3  Current pending count.
- `lost_cnt`  out  8  Saturating count of dropped or timed-out requests.

## Operation

- The state machine is registered and has four states: IDLE, ASSERT, ACKWAIT, GAP.
- IDLE:
  - `int_n` is 1.
  - If `pend != 0` and `int_en` is high, go to ASSERT, set `int_n` to 0 and clear the hold counter.
- ASSERT (`int_n` is 0; the hold counter increments every cycle). Conditions are evaluated in this priority order:
  1. `m1_n` and `iorq_n` both low: acknowledge. Set `int_n` to 1, pulse `ack_stb` for one cycle, decrement `pend`, go to ACKWAIT.
  2. `int_en` low: set `int_n` to 1 and go to IDLE. `pend` is unchanged and no loss is counted.
  3. Hold counter equals `HOLD_CYCLES-1`: timeout. Set `int_n` to 1, decrement `pend`, increment `lost_cnt`, go to GAP.
- ACKWAIT:
  - `int_n` is 1.
  - Remain in ACKWAIT until `m1_n` and `iorq_n` are both high, then go to GAP. This prevents a single acknowledge cycle from being counted twice.
- GAP:
  - `int_n` is 1 for exactly one cycle, then go to IDLE. This guarantees a visible rising edge on `int_n` between back-to-back interrupts.
- Pending counter:
  - `int_stb` increments `pend` when `pend < PEND_MAX`. If `pend == PEND_MAX`, `int_stb` increments `lost_cnt` instead.
  - A strobe in the same cycle as a decrement (acknowledge or timeout): `pend` is unchanged and the strobe is never lost, even when `pend == PEND_MAX`.
  - Strobes are queued regardless of `int_en`.
- Lost counter:
  - `lost_cnt` saturates at 255.
  - A timeout and a full-queue drop in the same cycle add 2, subject to saturation.
  - `lost_clr` has priority: the result is 0 even if loss events occur in the same cycle.
- Reset (`rst_n` sampled low at a clock edge):
  - State goes to IDLE, `int_n`=1, `ack_stb`=0, `pend`=0, `lost_cnt`=0, hold counter=0.
  - Reset during ASSERT releases `int_n` on that same edge.

## Timing

- Request to assertion: `int_stb` sampled high at edge E (pend 0 to 1, `int_en` high) makes `int_n` go low after edge E+1.
- Acknowledge: M1 and IORQ sampled low at edge A make `int_n` high and `ack_stb` high after edge A. `ack_stb` is low again after A+1.
- Timeout: `int_n` is low for exactly `HOLD_CYCLES` clock cycles, followed by exactly 1 GAP cycle, then IDLE.
- Minimum `int_n` high time between consecutive requests:
  - 2 cycles (GAP + IDLE) after a timeout.
  - 2 cycles after the acknowledge release (GAP + IDLE) after an acknowledge.
- `pend` and `lost_cnt` update on the edge that samples the causing event.

## Test plan

- Single strobe, `int_en`=1, no acknowledge, `HOLD_CYCLES`=32 -> `int_n` low for 32 cycles, then `pend`=0, `lost_cnt`=1, `int_n` high for at least 2 cycles.
- Single strobe, then M1+IORQ low for 3 cycles starting 5 cycles after `int_n` falls -> exactly one `ack_stb` pulse, `int_n` rises on the first acknowledge edge, `pend`=0, `lost_cnt`=0, no reassertion.
- 5 strobes with `int_en`=0 and `PEND_MAX`=3 -> `pend`=3, `lost_cnt`=2. Raise `int_en` and acknowledge each request -> 3 `int_n` pulses, each separated by at least 2 high cycles, final `pend`=0.
- `pend`=3, strobe coincident with the acknowledge edge -> `pend` stays 3, `lost_cnt` unchanged.
- `int_en` dropped mid-ASSERT -> `int_n` high next edge, `pend` unchanged. Re-enable -> `int_n` reasserts with a fresh `HOLD_CYCLES` window.
- Force 300 losses -> `lost_cnt`=255. `lost_clr` coincident with a loss -> 0. `rst_n` low mid-ASSERT -> all outputs at reset values on the next edge.
